// File: rtl/rr_arb4_pkg.sv
// Shared definitions for the four-way round-robin arbiter.
//   state_e : arbiter FSM encoding (IDLE = no owner, OWN = grant held)
//   N_REQ   : number of requesters
//   PTR_W   : width of a requester index / rotating pointer
package rr_arb4_pkg;

  localparam int N_REQ = 4;
  localparam int PTR_W = 2;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_e;

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin search over four candidates.
// The search starts at last+1 and wraps modulo 4.
//   cand  [3:0] : pending candidates
//   last  [1:0] : index of the most recent winner
//   win   [1:0] : first candidate found after last (0 when none)
//   found       : at least one candidate was set
module rr_pick4
  import rr_arb4_pkg::*;
(
  input  logic [N_REQ-1:0] cand,
  input  logic [PTR_W-1:0] last,
  output logic [PTR_W-1:0] win,
  output logic             found
);

  logic [PTR_W-1:0]   start;
  logic [2*N_REQ-1:0] dbl;
  logic [2*N_REQ-1:0] sh;
  logic [N_REQ-1:0]   rot;
  logic [PTR_W-1:0]   off;

  // Rotate right by the start index so the highest-priority requester sits
  // at bit 0; doubling the vector makes the wrap a plain shift.
  assign start = last + 1'b1;
  assign dbl   = {cand, cand};
  assign sh    = dbl >> start;
  assign rot   = sh[N_REQ-1:0];

  // Lowest set bit: scan downward so the lowest index is assigned last.
  always_comb begin
    off   = '0;
    found = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off   = PTR_W'(i);
        found = 1'b1;
      end
    end
  end

  // Undo the rotation; PTR_W-bit addition wraps modulo 4.
  assign win = found ? (start + off) : '0;

endmodule

// File: rtl/rr_arb4.sv
// Four-way round-robin arbiter with grant-until-release ownership.
// A winner keeps the resource while its request stays high; on release the
// grant hands straight over to the next pending requester, with no idle bubble.
// Optional feature: define RR_ARB4_HOLD_LIMIT_EN to force a handover after
// MAX_HOLD consecutive cycles when another requester is waiting.
//   clk         : clock, rising edge
//   rst         : synchronous active-high reset
//   req   [3:0] : request bits, held high while the resource is in use
//   grant [3:0] : registered one-hot grant, zero when unowned
//   out   [1:0] : registered owner index, zero when v is low
//   v           : registered grant-valid flag
module rr_arb4
  import rr_arb4_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [PTR_W-1:0] out,
  output logic             v
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("rr_arb4: MAX_HOLD must be in 2..255");
  end

  state_e           state_q, state_d;
  logic [PTR_W-1:0] last_q, last_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [PTR_W-1:0] out_q, out_d;
  logic             v_q, v_d;

  logic [N_REQ-1:0] cand;
  logic [PTR_W-1:0] win;
  logic             found;
  logic             force_ho;

  // While owning, the owner is excluded so a handover picks someone else.
  assign cand = (state_q == OWN) ? (req & ~(N_REQ'(1) << out_q)) : req;

  rr_pick4 u_pick (
    .cand  (cand),
    .last  (last_q),
    .win   (win),
    .found (found)
  );

`ifdef RR_ARB4_HOLD_LIMIT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] hold_cnt_q, hold_cnt_d;
  assign force_ho = (hold_cnt_q == HOLD_LAST) && found;
`else
  assign force_ho = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    grant_d = grant_q;
    out_d   = out_q;
    v_d     = v_q;
`ifdef RR_ARB4_HOLD_LIMIT_EN
    // Saturates at HOLD_LAST when nobody else is waiting.
    hold_cnt_d = (hold_cnt_q == HOLD_LAST) ? hold_cnt_q : hold_cnt_q + 8'd1;
`endif
    if (state_q == IDLE || !req[out_q] || force_ho) begin
      if (found) begin
        state_d = OWN;
        last_d  = win;
        grant_d = N_REQ'(1) << win;
        out_d   = win;
        v_d     = 1'b1;
`ifdef RR_ARB4_HOLD_LIMIT_EN
        hold_cnt_d = 8'd0;
`endif
      end else begin
        state_d = IDLE;
        grant_d = '0;
        out_d   = '0;
        v_d     = 1'b0;
`ifdef RR_ARB4_HOLD_LIMIT_EN
        hold_cnt_d = 8'd0;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= PTR_W'(N_REQ - 1);
      grant_q <= '0;
      out_q   <= '0;
      v_q     <= 1'b0;
`ifdef RR_ARB4_HOLD_LIMIT_EN
      hold_cnt_q <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      out_q   <= out_d;
      v_q     <= v_d;
`ifdef RR_ARB4_HOLD_LIMIT_EN
      hold_cnt_q <= hold_cnt_d;
`endif
    end
  end

  assign grant = grant_q;
  assign out   = out_q;
  assign v     = v_q;

endmodule

// File: doc/rr_arb4.md
# rr_arb4

Round-robin arbiter that shares one resource, such as a shared datapath or bus port, among four requesters. Each cycle it selects a winner from the pending request bits using a rotating priority pointer, then holds the grant until the owner releases. The winner's index and valid flag are encoded the same way the lab priority-encoder blocks present them. It sits between the four request sources and the shared resource's select input.

## Interface
Parameters:
- `MAX_HOLD`, default 8: maximum consecutive grant cycles for one owner. Used only when the hold-limit feature is compiled in. Legal range 2..255.

Ports:
- `clk`, input, 1: the single clock. All state updates on its rising edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `req`, input, 4: request bits. Bit i high means requester i wants the resource. A requester holds its bit high for as long as it uses the resource.
- `grant`, output, 4: one-hot grant, registered. All zeros when the resource is unowned.
- `out`, output, 2: index of the current owner, registered.
- `v`, output, 1: high when `grant` is nonzero, registered.

## Operation
- State machine with two states:
  - IDLE: no owner.
  - OWN: `grant` bit `out` is set.
- Rotating pointer `last` (2 bits) holds the index of the most recent winner.
- Search order starts at `last+1` and wraps modulo 4. The first pending requester in that order wins.
- Arbitration candidate set:
  - In IDLE: all of `req`.
  - In OWN on a release: `req` with the owner's bit masked off.
- IDLE transitions:
  - No bit of `req` set: stay in IDLE.
  - Any bit set: move to OWN with the winner, and set `last` to the winner.
- OWN transitions:
  - `req[out]` still 1: stay in OWN, outputs unchanged.
  - `req[out]` is 0 (release) and the masked candidate set is nonzero: move straight to the new winner with no idle bubble, and update `last`.
  - Release with no other request pending: go to IDLE. `grant`, `out` and `v` all read 0.
- Requests that arrive during OWN wait and are never lost.
- `out` reads 0 whenever `v` is 0.
- Reset:
  - State IDLE.
  - `grant` = 0, `out` = 0, `v` = 0.
  - `last` = 3, so requester 0 has first priority after reset.
- Reset mid-grant: the grant drops on the same edge that samples `rst` high. Pending requests are re-arbitrated from `last` = 3 on the first edge after `rst` returns low.

## Timing
- Latency from request to grant is 1 cycle. `req` is sampled on edge N, and `grant`, `out` and `v` are valid after edge N.
- Handover latency is 1 cycle. When the owner drops `req` before edge N, the new grant is valid after edge N.
- The arbiter never grants two requesters at once. `grant` is always one-hot or zero.
- Fairness: with all four requesting continuously and each releasing after one cycle of use, the grant order is 0, 1, 2, 3, 0, and so on.
- Outputs depend only on registers. There is no combinational path from `req` to any output.

## Configuration
- Macro `RR_ARB4_HOLD_LIMIT_EN`.
- Defined:
  - An 8-bit counter `hold_cnt` clears on every new grant and increments each cycle in OWN.
  - When `hold_cnt` = `MAX_HOLD-1` and the masked candidate set is nonzero, the next edge forces a handover exactly like a release, even though `req[out]` is still high.
  - The preempted requester keeps its request pending and competes again later.
  - If no other requester is pending, the owner keeps the grant and `hold_cnt` saturates at `MAX_HOLD-1`.
- Undefined: no counter exists, and an owner holds the grant for as long as `req[out]` stays high. `MAX_HOLD` is ignored.

## Structure
- Shared package `rr_arb4_pkg` holds:
  - The state encoding: `IDLE` = 1'b0, `OWN` = 1'b1.
  - The localparam `N_REQ` = 4.
  - The pointer width `PTR_W` = 2.
- Sub-module `rr_pick4` is combinational and contains the search logic:
  - Inputs: `cand[3:0]` and `last[1:0]`.
  - Outputs: `win[1:0]` and `found`.
  - It rotates `cand` right by `last+1`, takes the lowest set bit, and un-rotates the index.
- `rr_arb4` contains the state register, the pointer, the output registers and, under the macro, the hold counter.

## Test plan
- Reset, then `req` = 4'b0000 for 5 cycles. Required: `v` = 0, `grant` = 0, `out` = 0 throughout.
- Reset, then `req` = 4'b1010 for one edge. Required: `grant` = 4'b0010 and `out` = 1 one cycle later. Then drop bit 1. Required: `grant` = 4'b1000 and `out` = 3 on the next edge.
- All four requesting, each dropping its bit one cycle after being granted and re-raising it the cycle after. Required: `out` sequence 0, 1, 2, 3, 0, 1 and `v` continuously 1.
- Owner 2 holds `req[2]` for 20 cycles with the macro undefined while `req[0]` stays high. Required: `out` = 2 for all 20 cycles, then `out` = 0 one cycle after the release.
- Macro defined, `MAX_HOLD` = 4, `req` = 4'b0101 held high. Required: the grant alternates 0 and 2 every 4 cycles. With only `req[0]` high, `out` = 0 indefinitely.
- Assert `rst` for 1 cycle while `out` = 3 and `req` = 4'b1001. Required: `v` = 0 after that edge, then `out` = 0 one cycle after `rst` falls.
